// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_pkg
// Description : Shared constants, FSM state type and Z_257 arithmetic for the
//               4-point inverse NTT datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

    localparam int              CW    = 9;
    localparam logic [CW:0]     Q     = 10'd257;
    localparam logic [CW-1:0]   W_INV = 9'd241;
    localparam logic [CW-1:0]   N_INV = 9'd193;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_S1A   = 3'd1,
        ST_S1B   = 3'd2,
        ST_S2A   = 3'd3,
        ST_S2B   = 3'd4,
        ST_SCALE = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Single conditional subtract; enough for any 9-bit value.
    function automatic logic [CW-1:0] mod_reduce(input logic [CW-1:0] v);
        logic [CW:0] e;
        e = {1'b0, v};
        if (e >= Q) e = e - Q;
        return e[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] mod_add(input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic [CW:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= Q) s = s - Q;
        return s[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] mod_sub(input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic [CW:0] d;
        d = {1'b0, x} + Q - {1'b0, y};
        if (d >= Q) d = d - Q;
        return d[CW-1:0];
    endfunction

    // 2^8 == -1 (mod 257): fold the high byte of the product back as a subtract.
    function automatic logic [CW-1:0] mod_mul(input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic [2*CW-1:0] p;
        logic [CW:0]     lo;
        logic [CW:0]     hi;
        logic [CW:0]     r;
        p  = {{CW{1'b0}}, x} * {{CW{1'b0}}, y};
        lo = {2'b00, p[7:0]};
        hi = p[2*CW-1:8];
        r  = lo + Q - hi;
        if (r >= Q) r = r - Q;
        return r[CW-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/gs_butterfly.sv
`default_nettype none
// ============================================================================
// Module      : gs_butterfly
// Description : Combinational Gentleman-Sande butterfly over Z_257.
// Revision    : 1.0 - initial release
// ============================================================================
module gs_butterfly
    import ntt_pkg::*;
(
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic [CW-1:0] t,
    output logic [CW-1:0] x_out,
    output logic [CW-1:0] y_out
);

    assign x_out = mod_add(x, y);
    assign y_out = mod_mul(mod_sub(x, y), t);

endmodule
`default_nettype wire

// File: rtl/intt_4_seq.sv
`default_nettype none
// ============================================================================
// Module      : intt_4_seq
// Description : Sequential handshaked 4-point inverse NTT over Z_257 using one
//               shared butterfly. Define INTT_SCALE_EN to include the N^-1
//               scaling pass; otherwise the output is 4*a mod 257.
// Revision    : 1.0 - initial release
// ============================================================================
module intt_4_seq
    import ntt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*CW-1:0]   an_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*CW-1:0]   a_out,
    output logic              busy
);

    state_t              state_q, state_d;
    logic [CW-1:0]       r_q [4];
    logic [CW-1:0]       r_d [4];
    logic                out_valid_q, out_valid_d;
    logic [4*CW-1:0]     a_out_q, a_out_d;
`ifdef INTT_SCALE_EN
    logic [1:0]          cnt_q, cnt_d;
`endif

    logic [CW-1:0] bf_x, bf_y, bf_t, bf_xo, bf_yo;

    gs_butterfly u_bf (
        .x     (bf_x),
        .y     (bf_y),
        .t     (bf_t),
        .x_out (bf_xo),
        .y_out (bf_yo)
    );

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        out_valid_d = out_valid_q;
        a_out_d     = a_out_q;
`ifdef INTT_SCALE_EN
        cnt_d       = cnt_q;
`endif
        bf_x        = r_q[0];
        bf_y        = r_q[2];
        bf_t        = 9'd1;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    for (int k = 0; k < 4; k++) r_d[k] = mod_reduce(an_in[k*CW +: CW]);
                    state_d = ST_S1A;
                end
            end
            ST_S1A: begin
                r_d[0]  = bf_xo;
                r_d[2]  = bf_yo;
                state_d = ST_S1B;
            end
            ST_S1B: begin
                bf_x    = r_q[1];
                bf_y    = r_q[3];
                bf_t    = W_INV;
                r_d[1]  = bf_xo;
                r_d[3]  = bf_yo;
                state_d = ST_S2A;
            end
            ST_S2A: begin
                bf_x    = r_q[0];
                bf_y    = r_q[1];
                r_d[0]  = bf_xo;
                r_d[1]  = bf_yo;
                state_d = ST_S2B;
            end
            ST_S2B: begin
                bf_x    = r_q[2];
                bf_y    = r_q[3];
                r_d[2]  = bf_xo;
                r_d[3]  = bf_yo;
`ifdef INTT_SCALE_EN
                cnt_d   = 2'd0;
                state_d = ST_SCALE;
`else
                out_valid_d = 1'b1;
                a_out_d     = {r_d[3], r_d[1], r_d[2], r_d[0]};
                state_d     = ST_DONE;
`endif
            end
`ifdef INTT_SCALE_EN
            ST_SCALE: begin
                // y = 0 turns the butterfly's lower leg into a plain multiply.
                bf_x       = r_q[cnt_q];
                bf_y       = '0;
                bf_t       = N_INV;
                r_d[cnt_q] = bf_yo;
                cnt_d      = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    out_valid_d = 1'b1;
                    a_out_d     = {r_d[3], r_d[1], r_d[2], r_d[0]};
                    state_d     = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            a_out_q     <= '0;
            for (int k = 0; k < 4; k++) r_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            a_out_q     <= a_out_d;
            for (int k = 0; k < 4; k++) r_q[k] <= r_d[k];
        end
    end

`ifdef INTT_SCALE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 2'd0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign in_ready  = (state_q == ST_IDLE) & rst_n;
    assign out_valid = out_valid_q;
    assign a_out     = a_out_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_intt_4_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_intt_4_seq
// Description : Directed and round-trip bench for intt_4_seq (either build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intt_4_seq;

`ifdef INTT_SCALE_EN
    localparam int LAT = 9;
    localparam int SCL = 1;
`else
    localparam int LAT = 5;
    localparam int SCL = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [35:0] an_in = '0;
    logic        in_ready;
    logic        out_valid;
    logic [35:0] a_out;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    intt_4_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .an_in     (an_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] pack(input logic [8:0] c0, input logic [8:0] c1,
                                         input logic [8:0] c2, input logic [8:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    // Forward 4-point NTT with w = 16, the producer side of the round trip.
    function automatic logic [35:0] ntt_fwd(input logic [35:0] a);
        int wp [4] = '{1, 16, 256, 241};
        logic [35:0] r;
        int s;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            s = 0;
            for (int j = 0; j < 4; j++)
                s = (s + int'(a[9*j +: 9]) * wp[(j*k) % 4]) % 257;
            r[9*k +: 9] = s[8:0];
        end
        return r;
    endfunction

    function automatic logic [35:0] scl(input logic [35:0] v);
        logic [35:0] r;
        int s;
        for (int k = 0; k < 4; k++) begin
            s = (int'(v[9*k +: 9]) * SCL) % 257;
            r[9*k +: 9] = s[8:0];
        end
        return r;
    endfunction

    task automatic run_block(input logic [35:0] din, input logic [35:0] expv, input string name);
        int  lat;
        bit  got;
        bit  rdy;
        rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin rdy = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_tests++;
        if (!rdy) begin
            n_fail++;
            $display("FAIL %s_ready: in_ready=%0b required 1", name, in_ready);
        end
        in_valid = 1'b1;
        an_in    = din;
        @(posedge clk); #1;
        in_valid = 1'b0;
        an_in    = 36'hF_FFFF_FFFF;
        lat = 1;
        got = 1'b0;
        while (lat < 30) begin
            if (out_valid) begin got = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (!got || lat != LAT) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d (valid=%0b) required %0d", name, lat, got, LAT);
        end
        n_tests++;
        if (a_out !== expv) begin
            n_fail++;
            $display("FAIL %s_data: a_out=%h required %h", name, a_out, expv);
        end
        if (got && out_ready) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_handshake: out_valid=%0b in_ready=%0b required 0/1",
                         name, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || a_out !== 36'd0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: ov=%0b a=%h ir=%0b busy=%0b required 0/0/0/0",
                     out_valid, a_out, in_ready, busy);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ir=%0b busy=%0b required 1/0", in_ready, busy);
        end
    endtask

    task automatic test_directed;
        out_ready = 1'b1;
        run_block(pack(4, 0, 0, 0),   scl(pack(1, 1, 1, 1)), "delta");
        run_block(pack(1, 1, 1, 1),   scl(pack(1, 0, 0, 0)), "flat");
        run_block(pack(257, 0, 0, 0), pack(0, 0, 0, 0),      "nonreduced");
    endtask

    task automatic test_round_trip;
        logic [35:0] a;
        out_ready = 1'b1;
        run_block(pack(15, 158, 252, 93), scl(pack(1, 2, 4, 8)), "rt_const");
        n_tests++;
        if (ntt_fwd(pack(1, 2, 4, 8)) !== pack(15, 158, 252, 93)) begin
            n_fail++;
            $display("FAIL fwd_model: got %h required %h", ntt_fwd(pack(1, 2, 4, 8)),
                     pack(15, 158, 252, 93));
        end
        for (int i = 0; i < 200; i++) begin
            a = pack(9'($urandom_range(0, 256)), 9'($urandom_range(0, 256)),
                     9'($urandom_range(0, 256)), 9'($urandom_range(0, 256)));
            run_block(ntt_fwd(a), scl(a), "rt_rand");
        end
    endtask

    task automatic test_backpressure;
        logic [35:0] expv;
        bit got;
        expv = scl(pack(1, 1, 1, 1));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        an_in     = pack(4, 0, 0, 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL bp_valid: out_valid=%0b required 1", out_valid);
        end
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            an_in    = pack(1, 1, 1, 1);
            n_tests++;
            if (out_valid !== 1'b1 || a_out !== expv || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold: ov=%0b a=%h ir=%0b busy=%0b required 1/%h/0/1",
                         out_valid, a_out, in_ready, busy, expv);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_tests++;
        if (out_valid !== 1'b1 || a_out !== expv) begin
            n_fail++;
            $display("FAIL bp_final: ov=%0b a=%h required 1/%h", out_valid, a_out, expv);
        end
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: ov=%0b ir=%0b required 0/1", out_valid, in_ready);
        end
        run_block(pack(15, 158, 252, 93), scl(pack(1, 2, 4, 8)), "bp_second");
    endtask

    task automatic test_reset_mid_block;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        an_in     = pack(4, 0, 0, 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%0b required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || a_out !== 36'd0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: ov=%0b a=%h ir=%0b busy=%0b required 0/0/0/0",
                     out_valid, a_out, in_ready, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: ir=%0b ov=%0b required 1/0", in_ready, out_valid);
        end
        run_block(pack(1, 1, 1, 1), scl(pack(1, 0, 0, 0)), "mid_after");
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        run_block(pack(4, 0, 0, 0), scl(pack(1, 1, 1, 1)), "b2b_a");
        run_block(pack(1, 1, 1, 1), scl(pack(1, 0, 0, 0)), "b2b_b");
        run_block(pack(0, 0, 0, 0), pack(0, 0, 0, 0),      "b2b_c");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_round_trip();
        test_backpressure();
        test_reset_mid_block();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
